// File: rtl/polyphase_dec_ctrl.sv
// Polyphase decimator control: commutates input samples across M branches
// and sums the branch outputs into one decimated sample per frame.
module polyphase_dec_ctrl #(
  parameter int M             = 4,
  parameter int word_size_in  = 8,
  parameter int word_size_out = 20,
  parameter int BR_LAT        = 2,
  parameter int FLUSH_FRAMES  = 6
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  enable,
  input  logic                                  flush,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [word_size_in-1:0]               in_data,
  output logic [M-1:0]                          ph_en,
  output logic [word_size_in-1:0]               ph_x,
  input  logic [M*word_size_out-1:0]            br_y,
  output logic                                  out_valid,
  output logic [word_size_out+$clog2(M)-1:0]    out_data,
  output logic                                  busy
);

  localparam int PW = $clog2(M);
  localparam int WD = word_size_out + PW;
  localparam int NF = FLUSH_FRAMES * M;
  localparam int FW = $clog2(NF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_nx;
  logic [PW-1:0]            phase;
  logic [FW-1:0]            fcnt;
  logic [BR_LAT-1:0]        pend;
  logic [BR_LAT-1:0]        pend_nx;
  logic                     accept;
  logic                     enter_flush;
  logic                     fdone;
  logic                     load;
  logic [word_size_out-1:0] sl;
  logic [WD-1:0]            sum;

  assign accept      = in_valid & in_ready;
  assign enter_flush = flush && (state != FLUSH);
  assign fdone       = (state == FLUSH) && (fcnt == FW'(NF - 1));
  assign load        = ph_en[M-1] && (state != FLUSH);
  assign pend_nx     = (pend << 1) | BR_LAT'(load);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (flush) state_nx = FLUSH;
        else if (enable) state_nx = RUN;
      end
      RUN: begin
        if (flush) state_nx = FLUSH;
        else if (!enable) state_nx = IDLE;
      end
      FLUSH: begin
        if (fdone) state_nx = enable ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == RUN) && !flush;
    busy     = (state == FLUSH) || (|pend);
  end

  // Sign-extended full-precision sum of all branch slices
  always_comb begin
    sum = '0;
    sl  = '0;
    for (int k = 0; k < M; k++) begin
      sl  = br_y[k*word_size_out +: word_size_out];
      sum = sum + {{PW{sl[word_size_out-1]}}, sl};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase <= '0;
      fcnt  <= '0;
      ph_en <= '0;
      ph_x  <= '0;
    end else if (enter_flush) begin
      phase <= '0;
      fcnt  <= '0;
      ph_en <= M'(1);
      ph_x  <= '0;
    end else if (state == FLUSH) begin
      fcnt  <= fcnt + FW'(1);
      ph_en <= fdone ? '0 : {ph_en[M-2:0], ph_en[M-1]};
    end else if (accept) begin
      ph_en <= M'(1) << phase;
      ph_x  <= in_data;
      phase <= phase + PW'(1);
    end else begin
      ph_en <= '0;
    end
  end

  // Each bit of pend tracks one frame's last-branch enable toward sampling
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (enter_flush) begin
      pend      <= '0;
      out_valid <= 1'b0;
    end else begin
      pend      <= pend_nx;
      out_valid <= pend[BR_LAT-1];
      if (pend[BR_LAT-1]) out_data <= sum;
    end
  end

endmodule

// File: tb/tb_polyphase_dec_ctrl.sv
// Directed bench for polyphase_dec_ctrl: reset, stream, gapped input,
// flush, reset during countdown, and pause/resume.
module tb_polyphase_dec_ctrl;

  localparam int M  = 4;
  localparam int WI = 8;
  localparam int WO = 20;
  localparam int WD = WO + 2;

  localparam logic [WD-1:0] SUM_A   = 22'd58;
  localparam logic [WD-1:0] SUM_NEG = 22'h200000;
  localparam logic [WD-1:0] SUM_POS = 22'd2097148;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [WI-1:0]   in_data;
  logic [M-1:0]    ph_en;
  logic [WI-1:0]   ph_x;
  logic [M*WO-1:0] br_y;
  logic            out_valid;
  logic [WD-1:0]   out_data;
  logic            busy;

  logic signed [WO-1:0] v0, v1, v2, v3;
  logic d1 = 1'b0;
  logic d2 = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Branch model: slices are valid BR_LAT cycles after the last-branch enable
  always_ff @(posedge clk) begin
    d1 <= ph_en[M-1];
    d2 <= d1;
  end
  assign br_y = d2 ? {v3, v2, v1, v0} : '0;

  polyphase_dec_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .ph_en     (ph_en),
    .ph_x      (ph_x),
    .br_y      (br_y),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy)
  );

  function automatic logic [M-1:0] oh(input int k);
    logic [M-1:0] r;
    r = 4'b0001;
    return r << k;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [WI-1:0] xp;
    logic er;
    xp = '0;
    reset = 1'b0; enable = 1'b1; flush = 1'b0;
    in_valid = 1'b1; in_data = 8'h5A;
    v3 = 100; v2 = -50; v1 = 7; v0 = 1;

    // reset held for two edges
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_rdy", in_ready, 1'b0);
    chk("rst_en", ph_en, 4'b0);
    chk("rst_x", ph_x, 8'h00);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_od", out_data, 22'd0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("rst2_rdy", in_ready, 1'b0);
    chk("rst2_en", ph_en, 4'b0);
    chk("rst2_od", out_data, 22'd0);
    @(posedge clk); #1;

    // continuous stream of 8 samples
    for (int c = 0; c < 14; c++) begin
      in_valid = (c < 8);
      in_data = WI'(c + 1);
      @(negedge clk);
      chk("s_rdy", in_ready, 1'b1);
      chk("s_en", ph_en, (c >= 1 && c <= 8) ? oh((c - 1) % 4) : 4'b0);
      chk("s_x", ph_x, xp);
      chk("s_ov", out_valid, (c == 7 || c == 11));
      chk("s_od", out_data, (c >= 7) ? SUM_A : 22'd0);
      chk("s_busy", busy, (c == 5 || c == 6 || c == 9 || c == 10));
      if (in_valid) xp = in_data;
      @(posedge clk); #1;
    end

    // gapped input, most negative branch values
    v3 = -524288; v2 = -524288; v1 = -524288; v0 = -524288;
    for (int c = 0; c < 13; c++) begin
      in_valid = (c % 2 == 0) && (c < 8);
      in_data = in_valid ? WI'(8'h80 + c) : 8'hAA;
      @(negedge clk);
      chk("g_rdy", in_ready, 1'b1);
      chk("g_en", ph_en, (c % 2 == 1 && c <= 7) ? oh((c - 1) / 2) : 4'b0);
      chk("g_x", ph_x, xp);
      chk("g_ov", out_valid, (c == 10));
      chk("g_od", out_data, (c >= 10) ? SUM_NEG : SUM_A);
      if (in_valid) xp = in_data;
      @(posedge clk); #1;
    end

    // flush after two accepts, coinciding with in_valid
    for (int c = 0; c < 29; c++) begin
      in_valid = (c != 28);
      flush = (c == 2 || c == 10);
      in_data = (c == 0) ? 8'd11 : (c == 1) ? 8'd12 : (c == 27) ? 8'h33 : 8'h55;
      er = (c <= 1) || (c >= 27);
      @(negedge clk);
      chk("f_rdy", in_ready, er);
      chk("f_en", ph_en,
          (c == 1) ? oh(0) : (c == 2) ? oh(1) :
          (c >= 3 && c <= 26) ? oh((c - 3) % 4) :
          (c == 28) ? oh(0) : 4'b0);
      chk("f_x", ph_x, xp);
      chk("f_ov", out_valid, 1'b0);
      chk("f_od", out_data, SUM_NEG);
      chk("f_busy", busy, (c >= 3 && c <= 26));
      if (c == 2) xp = '0;
      else if (in_valid && er) xp = in_data;
      @(posedge clk); #1;
    end
    flush = 1'b0;

    // reset one cycle after the last-branch enable
    for (int c = 0; c < 10; c++) begin
      in_valid = (c <= 2);
      in_data = WI'(8'h21 + c);
      reset = (c != 4);
      er = (c != 5);
      @(negedge clk);
      chk("r_rdy", in_ready, er);
      chk("r_en", ph_en,
          (c == 1) ? oh(1) : (c == 2) ? oh(2) : (c == 3) ? oh(3) : 4'b0);
      chk("r_x", ph_x, xp);
      chk("r_ov", out_valid, 1'b0);
      chk("r_od", out_data, (c >= 5) ? 22'd0 : SUM_NEG);
      chk("r_busy", busy, (c == 4));
      if (c == 4) xp = '0;
      else if (in_valid && er) xp = in_data;
      @(posedge clk); #1;
    end
    reset = 1'b1;

    // pause after three accepts, then idle during the countdown
    v3 = 524287; v2 = 524287; v1 = 524287; v0 = 524287;
    for (int c = 0; c < 16; c++) begin
      enable = (c <= 2) || (c == 8) || (c == 9);
      in_valid = (c <= 2) || (c >= 4 && c <= 9);
      in_data = WI'(8'h40 + c);
      er = (c <= 3) || (c == 9) || (c == 10);
      @(negedge clk);
      chk("p_rdy", in_ready, er);
      chk("p_en", ph_en,
          (c == 1) ? oh(0) : (c == 2) ? oh(1) : (c == 3) ? oh(2) :
          (c == 10) ? oh(3) : 4'b0);
      chk("p_x", ph_x, xp);
      chk("p_ov", out_valid, (c == 13));
      chk("p_od", out_data, (c >= 13) ? SUM_POS : 22'd0);
      chk("p_busy", busy, (c == 11 || c == 12));
      if (in_valid && er) xp = in_data;
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
